cdc_handshake_tx_vdma: RTL and testbench

Source-side half of a toggle-based request/acknowledge bus crossing for the VDMA clock-domain boundaries. Captures a multi-bit word on a valid/ready handshake in the `sys_clk_i` domain and holds it stable on `xfer_data_o`. Signals it across by toggling `xfer_req_o`, then waits for the destination's toggled acknowledge. The acknowledge is re-timed internally through a 2-stage synchronizer; the destination end samples `xfer_req_o` with its own 2-stage synchronizer before capturing the held data.

---
 rtl/cdc_handshake_tx_vdma.sv | 107 ++++++++++
 tb/tb_cdc_handshake_tx_vdma.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx_vdma.sv
// cdc_handshake_tx_vdma
//   Source half of a toggle request/acknowledge bus crossing used on the VDMA
//   clock-domain boundaries. A word accepted on the valid/ready handshake is
//   held on xfer_data_o. The block then toggles xfer_req_o and waits until the
//   re-synchronized acknowledge toggle matches the request level.
//
// Ports
//   sys_clk_i    source-domain clock
//   rstn_i       asynchronous active-low reset
//   data_i       word to transfer
//   valid_i      data_i valid
//   ready_o      block can accept a word (registered)
//   xfer_data_o  held word toward destination, stable while a transfer is open
//   xfer_req_o   request toggle toward destination (registered)
//   xfer_ack_i   acknowledge toggle from destination (asynchronous)
//   done_o       one-cycle pulse when the acknowledge for the word is seen
//   timeout_o    sticky flag: acknowledge overdue
//   clear_err_i  clears timeout_o (a coincident new timeout wins)
module cdc_handshake_tx_vdma #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  sys_clk_i,
   input  logic                  rstn_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [DATA_WIDTH-1:0] xfer_data_o,
   output logic                  xfer_req_o,
   input  logic                  xfer_ack_i,
   output logic                  done_o,
   output logic                  timeout_o,
   input  logic                  clear_err_i
);

   // A zero-width counter is not legal, so a disabled timeout keeps one bit.
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 32'd0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic {
      IDLE,
      WAIT_ACK
   } state_t;

   state_t           state;
   logic             ack_s1;
   logic             ack_s2;
   logic [CNT_W-1:0] tmo_cnt;

   // Two-flop synchronizer for the asynchronous acknowledge toggle.
   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ack_s1 <= 1'b0;
         ack_s2 <= 1'b0;
      end else begin
         ack_s1 <= xfer_ack_i;
         ack_s2 <= ack_s1;
      end
   end

   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state       <= IDLE;
         ready_o     <= 1'b1;
         xfer_data_o <= '0;
         xfer_req_o  <= 1'b0;
         done_o      <= 1'b0;
         timeout_o   <= 1'b0;
         tmo_cnt     <= '0;
      end else begin
         done_o <= 1'b0;
         // Clear first so that a timeout set below overrides it.
         if (clear_err_i) begin
            timeout_o <= 1'b0;
         end
         case (state)
            IDLE: begin
               // A stray acknowledge level here is deliberately ignored.
               if (valid_i && ready_o) begin
                  xfer_data_o <= data_i;
                  xfer_req_o  <= ~xfer_req_o;
                  ready_o     <= 1'b0;
                  tmo_cnt     <= '0;
                  state       <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if ((TIMEOUT_CYCLES != 32'd0) && (tmo_cnt != CNT_MAX)) begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
                  if (tmo_cnt == CNT_LAST) begin
                     timeout_o <= 1'b1;
                  end
               end
               // The transfer is never abandoned: a late acknowledge still
               // completes it even after timeout_o has been raised.
               if (ack_s2 == xfer_req_o) begin
                  done_o  <= 1'b1;
                  ready_o <= 1'b1;
                  state   <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cdc_handshake_tx_vdma.sv
// tb_cdc_handshake_tx_vdma
//   Self-checking bench for cdc_handshake_tx_vdma (DATA_WIDTH 32,
//   TIMEOUT_CYCLES 16). A transfer-level reference model predicts the outputs
//   after every clock edge. The acknowledge it uses is the bench's own
//   xfer_ack_i value from two edges earlier. A small destination model
//   answers each request toggle after a programmable delay.
module tb_cdc_handshake_tx_vdma;

   localparam int DW  = 32;
   localparam int TMO = 16;

   logic          clk      = 1'b0;
   logic          rstn     = 1'b0;
   logic [DW-1:0] data     = '0;
   logic          valid    = 1'b0;
   logic          clear    = 1'b0;
   logic          xfer_ack = 1'b0;
   logic          ready;
   logic          req;
   logic          done;
   logic          tmo;
   logic [DW-1:0] xdata;

   always #5 clk = ~clk;

   cdc_handshake_tx_vdma #(
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .sys_clk_i   (clk),
      .rstn_i      (rstn),
      .data_i      (data),
      .valid_i     (valid),
      .ready_o     (ready),
      .xfer_data_o (xdata),
      .xfer_req_o  (req),
      .xfer_ack_i  (xfer_ack),
      .done_o      (done),
      .timeout_o   (tmo),
      .clear_err_i (clear)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Edge bookkeeping: cyc numbers posedges; ack_edge holds the ack level at each edge.
   int   cyc           = 0;
   int   last_rst_edge = 0;
   logic ack_edge [0:16383];

   always @(posedge clk) begin
      cyc = cyc + 1;
      ack_edge[cyc] = xfer_ack;
      if (!rstn) last_rst_edge = cyc;
   end

   // Reference model state (transfer level)
   logic          m_busy    = 1'b0;
   logic          m_req     = 1'b0;
   logic [DW-1:0] m_data    = '0;
   logic          m_done    = 1'b0;
   logic          m_tmo     = 1'b0;
   int            m_elapsed = 0;

   // Destination responder
   logic ack_auto    = 1'b0;
   int   ack_delay   = 4;
   int   ack_cnt     = 0;
   int   ack_tog_cyc = -100;

   // Predict the outputs after edge cyc from the inputs present at that edge.
   task automatic model_edge();
      logic a;
      logic reached;
      if (!rstn) begin
         m_busy = 1'b0; m_req = 1'b0; m_data = '0;
         m_done = 1'b0; m_tmo = 1'b0; m_elapsed = 0;
         return;
      end
      // The acknowledge becomes visible to the source logic two edges after it is sampled.
      a = (cyc >= 2 && (cyc - 2) > last_rst_edge) ? ack_edge[cyc-2] : 1'b0;
      reached = 1'b0;
      m_done  = 1'b0;
      if (m_busy) begin
         if (TMO > 0 && m_elapsed < TMO) begin
            m_elapsed++;
            reached = (m_elapsed == TMO);
         end
         if (a == m_req) begin
            m_done = 1'b1;
            m_busy = 1'b0;
         end
      end else if (valid) begin
         m_data    = data;
         m_req     = ~m_req;
         m_busy    = 1'b1;
         m_elapsed = 0;
      end
      if (reached) m_tmo = 1'b1;
      else if (clear) m_tmo = 1'b0;
   endtask

   task automatic step();
      @(negedge clk);
      model_edge();
      if (ack_auto && (req !== xfer_ack)) begin
         ack_cnt++;
         if (ack_cnt >= ack_delay) begin
            xfer_ack    = req;
            ack_cnt     = 0;
            ack_tog_cyc = cyc;
         end
      end else begin
         ack_cnt = 0;
      end
   endtask

   task automatic apply_reset();
      rstn = 1'b0; valid = 1'b0; clear = 1'b0; ack_auto = 1'b0; xfer_ack = 1'b0;
      step();
      step();
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      vectors++;
      if ({ready, req, done, tmo, xdata} !== {1'b1, 1'b0, 1'b0, 1'b0, {DW{1'b0}}}) begin
         miscompares++;
         $display("FAIL reset_values got r/q/d/t/data=%b%b%b%b/%h want 1000/0", ready, req, done, tmo, xdata);
      end
      step();
      vectors++;
      if ({ready, req, done, tmo} !== 4'b1000) begin
         miscompares++;
         $display("FAIL reset_idle got r/q/d/t=%b%b%b%b want 1000", ready, req, done, tmo);
      end
   endtask

   task automatic test_single();
      int ndone;
      int done_cyc;
      apply_reset();
      ack_auto = 1'b1; ack_delay = 4;
      repeat (3) step();
      data = 32'hA5A5_0001; valid = 1'b1;
      step();
      valid = 1'b0; data = $urandom;
      vectors++;
      if ({req, ready, xdata} !== {1'b1, 1'b0, 32'hA5A5_0001}) begin
         miscompares++;
         $display("FAIL single_accept got req=%b ready=%b data=%h want 1 0 a5a50001", req, ready, xdata);
      end
      ndone = 0; done_cyc = -1;
      for (int i = 0; i < 30; i++) begin
         step();
         vectors++;
         if ({ready, req, done, tmo, xdata} !== {~m_busy, m_req, m_done, m_tmo, m_data}) begin
            miscompares++;
            $display("FAIL single_model cyc=%0d got r/q/d/t/data=%b%b%b%b/%h want %b%b%b%b/%h",
                     cyc, ready, req, done, tmo, xdata, ~m_busy, m_req, m_done, m_tmo, m_data);
         end
         if (done === 1'b1) begin ndone++; done_cyc = cyc; end
      end
      vectors++;
      if (ndone != 1 || done_cyc != ack_tog_cyc + 3) begin
         miscompares++;
         $display("FAIL single_done_timing got pulses=%0d at=%0d want 1 at %0d", ndone, done_cyc, ack_tog_cyc + 3);
      end
   endtask

   task automatic test_back_to_back();
      int   toggles;
      logic pd;
      logic prev_req;
      logic [DW-1:0] held;
      apply_reset();
      ack_auto = 1'b1; ack_delay = $urandom_range(1, 5);
      data = 32'd1; valid = 1'b1; toggles = 0; held = xdata;
      for (int i = 0; i < 200 && toggles < 4; i++) begin
         pd = done; prev_req = req;
         step();
         vectors++;
         if ({ready, req, done, tmo, xdata} !== {~m_busy, m_req, m_done, m_tmo, m_data}) begin
            miscompares++;
            $display("FAIL b2b_model cyc=%0d got r/q/d/t/data=%b%b%b%b/%h want %b%b%b%b/%h",
                     cyc, ready, req, done, tmo, xdata, ~m_busy, m_req, m_done, m_tmo, m_data);
         end
         if (req !== prev_req) begin
            toggles++;
            vectors++;
            if ((toggles > 1 && pd !== 1'b1) || xdata !== DW'(toggles)) begin
               miscompares++;
               $display("FAIL b2b_accept word=%0d got done_before=%b data=%h want 1 %h", toggles, pd, xdata, DW'(toggles));
            end
            data = DW'(toggles + 1);
            ack_delay = $urandom_range(1, 5);
            if (toggles == 4) valid = 1'b0;
         end else if (ready === 1'b0 && xdata !== held) begin
            vectors++;
            miscompares++;
            $display("FAIL b2b_hold cyc=%0d got data=%h want %h", cyc, xdata, held);
         end
         held = xdata;
      end
      for (int i = 0; i < 20 && done !== 1'b1; i++) step();
      vectors++;
      if (toggles != 4 || req !== 1'b0 || done !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_final got toggles=%0d req=%b done=%b want 4 0 1", toggles, req, done);
      end
   endtask

   task automatic test_stall();
      logic [DW-1:0] w;
      logic seen;
      apply_reset();
      w = $urandom; data = w; valid = 1'b1;
      step();
      for (int i = 0; i < 50; i++) begin
         data = $urandom; valid = 1'b1;
         step();
         vectors++;
         if ({ready, req, done, tmo, xdata} !== {~m_busy, m_req, m_done, m_tmo, m_data}
             || xdata !== w || req !== 1'b1 || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold cyc=%0d got r/q/d/t/data=%b%b%b%b/%h want 01?%b/%h",
                     cyc, ready, req, done, tmo, xdata, m_tmo, w);
         end
      end
      valid = 1'b0; xfer_ack = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         step();
         if (done === 1'b1) seen = 1'b1;
      end
      vectors++;
      if (!seen || xdata !== w) begin
         miscompares++;
         $display("FAIL stall_complete got done_seen=%b data=%h want 1 %h", seen, xdata, w);
      end
      clear = 1'b1; step(); clear = 1'b0;
   endtask

   task automatic test_timeout();
      int   acc;
      logic seen;
      apply_reset();
      data = $urandom; valid = 1'b1;
      step();
      valid = 1'b0; acc = cyc;
      for (int i = 0; i < 26; i++) begin
         step();
         vectors++;
         if (tmo !== ((cyc - acc) >= TMO) || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_rise cyc=%0d got tmo=%b ready=%b want %b 0", cyc, tmo, ready, (cyc - acc) >= TMO);
         end
      end
      xfer_ack = ~xfer_ack;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         step();
         if (done === 1'b1) seen = 1'b1;
      end
      vectors++;
      if (!seen || tmo !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_late_ack got done_seen=%b tmo=%b want 1 1", seen, tmo);
      end
      clear = 1'b1; step(); clear = 1'b0;
      vectors++;
      if (tmo !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_clear got tmo=%b want 0", tmo);
      end
      // Second timeout with clear asserted on the very edge it fires.
      data = $urandom; valid = 1'b1;
      step();
      valid = 1'b0; acc = cyc;
      repeat (TMO - 1) step();
      vectors++;
      if (tmo !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_early got tmo=%b want 0", tmo);
      end
      clear = 1'b1; step(); clear = 1'b0;
      vectors++;
      if (tmo !== 1'b1 || cyc - acc != TMO) begin
         miscompares++;
         $display("FAIL timeout_set_wins got tmo=%b at +%0d want 1 at +%0d", tmo, cyc - acc, TMO);
      end
      step();
      vectors++;
      if (tmo !== m_tmo || tmo !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_sticky got tmo=%b want 1", tmo);
      end
      xfer_ack = ~xfer_ack;
      repeat (5) step();
      clear = 1'b1; step(); clear = 1'b0;
   endtask

   task automatic test_spurious_reset();
      apply_reset();
      xfer_ack = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         vectors++;
         if (done !== 1'b0 || ready !== 1'b1 || {req, tmo} !== {m_req, m_tmo}) begin
            miscompares++;
            $display("FAIL spurious_ack cyc=%0d got done=%b ready=%b want 0 1", cyc, done, ready);
         end
      end
      xfer_ack = 1'b0;
      repeat (3) step();
      ack_auto = 1'b1; ack_delay = 8;
      data = $urandom | 32'h1; valid = 1'b1;
      step();
      valid = 1'b0;
      repeat (3) step();
      ack_auto = 1'b0;
      vectors++;
      if (ready !== 1'b0 || req !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_precond got ready=%b req=%b want 0 1", ready, req);
      end
      #3 rstn = 1'b0;
      #1;
      vectors++;
      if ({ready, req, done, tmo, xdata} !== {1'b1, 1'b0, 1'b0, 1'b0, {DW{1'b0}}}) begin
         miscompares++;
         $display("FAIL reset_async got r/q/d/t/data=%b%b%b%b/%h want 1000/0", ready, req, done, tmo, xdata);
      end
      step();
      step();
      rstn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         vectors++;
         if (done !== 1'b0 || {ready, req, tmo, xdata} !== {~m_busy, m_req, m_tmo, m_data}) begin
            miscompares++;
            $display("FAIL reset_no_done cyc=%0d got r/q/d/t=%b%b%b%b want 1000", cyc, ready, req, done, tmo);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_timeout();
      test_spurious_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
